// File: rtl/wr_frame_feeder_if.sv
// wr_frame_feeder_if: write-port bundle between the frame feeder and the DDR controller.
// master = feeder (command/data source), slave = controller.
interface wr_frame_feeder_if #(
    parameter int CTRL_ADDR_WIDTH = 28,
    parameter int MEM_DQ_WIDTH    = 16
);
    logic                         wr_en;
    logic [CTRL_ADDR_WIDTH-1:0]   wr_addr;
    logic [3:0]                   wr_id;
    logic [3:0]                   wr_len;
    logic                         wr_ready;
    logic [MEM_DQ_WIDTH*8-1:0]    wr_data;
    logic                         wr_cmd_done;
    logic                         wr_done;

    modport master (
        output wr_en, wr_addr, wr_id, wr_len, wr_data, wr_done,
        input  wr_ready, wr_cmd_done
    );

    modport slave (
        input  wr_en, wr_addr, wr_id, wr_len, wr_data, wr_done,
        output wr_ready, wr_cmd_done
    );
endinterface

// File: rtl/wr_frame_feeder.sv
// wr_frame_feeder: packs pixels into beats, buffers them, issues linear write bursts.
// Define WR_FEEDER_PINGPONG_EN to alternate frames between FRAME_BASE0/FRAME_BASE1.
module wr_frame_feeder #(
    parameter int                         CTRL_ADDR_WIDTH = 28,
    parameter int                         MEM_DQ_WIDTH    = 16,
    parameter int                         PIX_WIDTH       = 16,
    parameter int                         BURST_LEN       = 16,
    parameter int                         FRAME_BEATS     = 115200,
    parameter int                         FIFO_DEPTH      = 64,
    parameter logic [CTRL_ADDR_WIDTH-1:0] FRAME_BASE0     = 28'h0000000,
    parameter logic [CTRL_ADDR_WIDTH-1:0] FRAME_BASE1     = 28'h0200000,
    parameter logic [3:0]                 WR_ID           = 4'd0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 pix_vsync,
    input  logic                 pix_de,
    input  logic [PIX_WIDTH-1:0] pix_data,
    wr_frame_feeder_if.master    wr,
    output logic                 frame_sel,
    output logic                 fifo_ovf
);
    localparam int BEAT_W = MEM_DQ_WIDTH * 8;
    localparam int PPB    = BEAT_W / PIX_WIDTH;
    localparam int PCW    = (PPB > 1) ? $clog2(PPB) : 1;
    localparam int AW     = $clog2(FIFO_DEPTH);
    localparam int FCW    = $clog2(FRAME_BEATS + 1);
    localparam int BCW    = 5;

    typedef enum logic [1:0] {IDLE, REQ, DATA, DONE} state_t;

    state_t                     state, state_nx;
    logic                       vs_q, start_pend, armed;
    logic [PCW-1:0]             pack_cnt;
    logic [PIX_WIDTH-1:0]       pix_buf [PPB];
    logic                       push_q;
    logic [BEAT_W-1:0]          beat_w;
    logic [BEAT_W-1:0]          mem [FIFO_DEPTH];
    logic [AW-1:0]              rd_ptr, wr_ptr;
    logic [AW:0]                fifo_count;
    logic [BCW-1:0]             beat_cnt;
    logic [FCW-1:0]             frame_cnt;
    logic [CTRL_ADDR_WIDTH-1:0] addr_q;
    logic                       vs_rise, consume, pix_take;
    logic                       fifo_empty, fifo_full;
    logic                       push_ok, pop, last_beat, frame_end;
    logic                       wr_en_c, wr_done_c;

    assign vs_rise    = pix_vsync & ~vs_q;
    assign pix_take   = pix_de & armed;
    assign fifo_empty = (fifo_count == '0);
    assign fifo_full  = (fifo_count == (AW+1)'(FIFO_DEPTH));
    assign push_ok    = push_q & ~fifo_full;
    assign pop        = (state == DATA) & wr.wr_ready & ~fifo_empty;
    assign last_beat  = (state == DATA) & wr.wr_ready
                      & (beat_cnt == BCW'(BURST_LEN - 1));
    assign frame_end  = (frame_cnt + FCW'(BURST_LEN)) == FCW'(FRAME_BEATS);

    assign wr.wr_en   = wr_en_c;
    assign wr.wr_done = wr_done_c;
    assign wr.wr_addr = addr_q;
    assign wr.wr_id   = WR_ID;
    assign wr.wr_len  = 4'(BURST_LEN - 1);
    assign wr.wr_data = fifo_empty ? '0 : mem[rd_ptr];

    // Assemble the beat from pixel slots, pixel 0 in the LSBs.
    always_comb begin
        beat_w = '0;
        for (int i = 0; i < PPB; i++)
            beat_w[i*PIX_WIDTH +: PIX_WIDTH] = pix_buf[i];
    end

    // Vsync edge detection and pending frame-start request.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vs_q       <= 1'b0;
            start_pend <= 1'b0;
        end else begin
            vs_q <= pix_vsync;
            if (vs_rise)
                start_pend <= 1'b1;
            else if (consume)
                start_pend <= 1'b0;
        end
    end

    // Pack counter; the completed beat is pushed one cycle after its last pixel.
    always_ff @(posedge clk) begin
        if (!rst_n || consume) begin
            pack_cnt <= '0;
            push_q   <= 1'b0;
        end else begin
            push_q <= pix_take && (pack_cnt == PCW'(PPB - 1));
            if (pix_take)
                pack_cnt <= (pack_cnt == PCW'(PPB - 1)) ? '0 : pack_cnt + 1'b1;
        end
    end

    // Pixel slot storage (data only, no reset needed).
    always_ff @(posedge clk) begin
        if (pix_take)
            pix_buf[pack_cnt] <= pix_data;
    end

    // Beat FIFO pointers and occupancy; a frame start flushes it.
    always_ff @(posedge clk) begin
        if (!rst_n || consume) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            unique case ({push_ok, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Beat FIFO storage.
    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr] <= beat_w;
    end

    // Sticky overflow, cleared only by a new frame sync.
    always_ff @(posedge clk) begin
        if (!rst_n)
            fifo_ovf <= 1'b0;
        else if (vs_rise)
            fifo_ovf <= 1'b0;
        else if (push_q && fifo_full && !consume)
            fifo_ovf <= 1'b1;
    end

    // State register plus burst/frame counters, address and frame arming.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            beat_cnt  <= '0;
            frame_cnt <= '0;
            addr_q    <= FRAME_BASE0;
            armed     <= 1'b0;
            frame_sel <= 1'b0;
        end else begin
            state <= state_nx;
            if (consume) begin
                frame_cnt <= '0;
                addr_q    <= frame_sel ? FRAME_BASE1 : FRAME_BASE0;
                armed     <= 1'b1;
            end
            if (state == DATA && wr.wr_ready)
                beat_cnt <= last_beat ? '0 : beat_cnt + 1'b1;
            if (last_beat) begin
                frame_cnt <= frame_cnt + FCW'(BURST_LEN);
                addr_q    <= addr_q + CTRL_ADDR_WIDTH'(BURST_LEN * 8);
            end
            if (state == DONE) begin
                armed <= 1'b0;
`ifdef WR_FEEDER_PINGPONG_EN
                frame_sel <= ~frame_sel;
`else
                frame_sel <= 1'b0;
`endif
            end
        end
    end

    // Next-state and command/done strobes.
    always_comb begin
        state_nx  = state;
        consume   = 1'b0;
        wr_en_c   = 1'b0;
        wr_done_c = 1'b0;
        unique case (state)
            IDLE: begin
                if (start_pend)
                    consume = 1'b1;
                else if (armed && fifo_count >= (AW+1)'(BURST_LEN))
                    state_nx = REQ;
            end
            REQ: begin
                wr_en_c  = 1'b1;
                state_nx = DATA;
            end
            DATA: begin
                if (last_beat)
                    state_nx = frame_end ? DONE : IDLE;
            end
            DONE: begin
                wr_done_c = 1'b1;
                state_nx  = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end
endmodule

// File: tb/tb_wr_frame_feeder.sv
// tb_wr_frame_feeder: scoreboard bench; a small controller model serves bursts.
// Expected beats are packed from driven pixels and popped on each wr_ready beat.
module tb_wr_frame_feeder;
    localparam int          BL    = 16;
    localparam int          FB    = 32;
    localparam logic [27:0] BASE0 = 28'h0000000;
    localparam logic [27:0] BASE1 = 28'h0200000;
`ifdef WR_FEEDER_PINGPONG_EN
    localparam bit PP = 1'b1;
`else
    localparam bit PP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pix_vsync = 1'b0;
    logic        pix_de = 1'b0;
    logic [15:0] pix_data = '0;
    logic        frame_sel, fifo_ovf;

    wr_frame_feeder_if #(.CTRL_ADDR_WIDTH(28), .MEM_DQ_WIDTH(16)) bus ();

    wr_frame_feeder #(.FRAME_BEATS(FB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pix_vsync (pix_vsync),
        .pix_de    (pix_de),
        .pix_data  (pix_data),
        .wr        (bus.master),
        .frame_sel (frame_sel),
        .fifo_ovf  (fifo_ovf)
    );

    always #5 clk = ~clk;

    int           checks = 0;
    int           errors = 0;
    logic [127:0] exp_q [$];
    logic [127:0] acc = '0;
    logic [27:0]  exp_addr = BASE0;
    logic [15:0]  pval = '0;
    bit           exp_sel = 1'b0;
    bit           hold = 1'b0;
    int           k = 0, cyc = 0, gap = 0, left = 0;
    int           en_cnt = 0, done_cnt = 0, served = 0;
    int           en_cyc = 0, last_beat_cyc = 0;

    task automatic chk(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        if (bus.wr_en) begin
            en_cnt++;
            en_cyc = cyc;
            chk("addr", bus.wr_addr, exp_addr);
            chk("len", bus.wr_len, 4'd15);
            chk("id", bus.wr_id, 4'd0);
            exp_addr += 28'h80;
            gap = 2;
        end
        if (bus.wr_ready) begin
            served++;
            if (exp_q.size() == 0) chk("beat_extra", 1, 0);
            else chk("beat", bus.wr_data, exp_q.pop_front());
            if (left == 1) last_beat_cyc = cyc;
            left--;
        end
        if (bus.wr_done) begin
            done_cnt++;
            chk("done_lat", cyc - last_beat_cyc, 1);
            if (PP) exp_sel = ~exp_sel;
        end
        @(negedge clk);
        cyc++;
        if (gap > 0) begin
            gap--;
            if (gap == 0) left = BL;
        end
        bus.wr_ready    = (left > 0) && !hold;
        bus.wr_cmd_done = bus.wr_ready && (left == 1);
    endtask

    task automatic pix(input int n);
        for (int i = 0; i < n; i++) begin
            pix_de   = 1'b1;
            pix_data = pval;
            acc[k*16 +: 16] = pval;
            k++;
            pval++;
            if (k == 8) begin
                exp_q.push_back(acc);
                k = 0;
            end
            tick();
        end
        pix_de = 1'b0;
    endtask

    task automatic settle();
        int t = 0;
        int quiet = 0;
        while (quiet < 6 && t < 600) begin
            tick();
            t++;
            if (left > 0 || gap > 0) quiet = 0;
            else quiet++;
        end
        if (t >= 600) chk("settle_timeout", 1, 0);
    endtask

    task automatic vsync();
        pix_vsync = 1'b1;
        tick();
        pix_vsync = 1'b0;
        settle();
        exp_q.delete();
        k = 0;
        exp_addr = exp_sel ? BASE1 : BASE0;
    endtask

    initial begin
        int e0, s0, d0, lp, t;
        bus.wr_ready    = 1'b0;
        bus.wr_cmd_done = 1'b0;
        @(negedge clk);
        repeat (3) tick();
        chk("rst_en", bus.wr_en, 0);
        chk("rst_done", bus.wr_done, 0);
        chk("rst_addr", bus.wr_addr, BASE0);
        chk("rst_len", bus.wr_len, 15);
        chk("rst_data", bus.wr_data, 0);
        chk("rst_sel", frame_sel, 0);
        chk("rst_ovf", fifo_ovf, 0);
        rst_n = 1'b1;
        tick();

        // single burst
        vsync();
        pix(128);
        settle();
        chk("t1_en", en_cnt, 1);
        chk("t1_beats", served, 16);
        chk("t1_q", exp_q.size(), 0);

        // complete frame, then next frame base
        pix(128);
        settle();
        chk("t2_en", en_cnt, 2);
        chk("t2_done", done_cnt, 1);
        chk("t2_sel", frame_sel, PP);
        vsync();
        pix(128);
        settle();
        chk("t2_en2", en_cnt, 3);
        chk("t2_sel2", frame_sel, exp_sel);

        // overflow with wr_ready held low
        vsync();
        d0 = done_cnt;
        hold = 1'b1;
        pix(520);
        repeat (5) tick();
        chk("ovf_set", fifo_ovf, 1);
        void'(exp_q.pop_back());
        chk("ovf_head", bus.wr_data, exp_q[0]);
        hold = 1'b0;
        settle();
        chk("ovf_keep", fifo_ovf, 1);
        chk("t3_done", done_cnt, d0 + 1);
        chk("t3_left", exp_q.size(), 32);
        vsync();
        chk("ovf_clr", fifo_ovf, 0);

        // vsync in the middle of a burst
        pix(128);
        t = 0;
        while (left != 11 && t < 200) begin
            tick();
            t++;
        end
        chk("t4_reach", t < 200, 1);
        s0 = served;
        vsync();
        chk("t4_rest", served - s0, 11);
        chk("t4_addr", bus.wr_addr, exp_addr);
        e0 = en_cnt;
        pix(128);
        settle();
        chk("t4_en", en_cnt, e0 + 1);

        // 15 beats do not trigger, the 16th does
        e0 = en_cnt;
        pix(120);
        repeat (10) tick();
        chk("t5_noen", en_cnt, e0);
        pix(8);
        lp = cyc - 1;
        settle();
        chk("t5_en", en_cnt, e0 + 1);
        chk("t5_lat", (en_cyc - lp) <= 3, 1);

        // reset during DATA
        vsync();
        pix(128);
        t = 0;
        while (!(left > 0 && left <= 13) && t < 200) begin
            tick();
            t++;
        end
        chk("t6_reach", t < 200, 1);
        rst_n = 1'b0;
        left = 0;
        gap = 0;
        bus.wr_ready = 1'b0;
        bus.wr_cmd_done = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("t6_en", bus.wr_en, 0);
        chk("t6_done", bus.wr_done, 0);
        chk("t6_addr", bus.wr_addr, BASE0);
        chk("t6_data", bus.wr_data, 0);
        chk("t6_sel", frame_sel, 0);
        chk("t6_ovf", fifo_ovf, 0);
        exp_sel = 1'b0;
        exp_addr = BASE0;
        e0 = en_cnt;
        pix(128);
        repeat (10) tick();
        exp_q.delete();
        k = 0;
        chk("t6_noen", en_cnt, e0);
        vsync();
        pix(128);
        settle();
        chk("t6_en2", en_cnt, e0 + 1);
        chk("t6_q", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/wr_frame_feeder.md
Name: wr_frame_feeder

Overview:
- Upstream stage of the DDR write controller: packs a single-clock video pixel stream into MEM_DQ_WIDTH*8-bit beats and buffers them in an internal show-ahead FIFO.
- Issues fixed-length burst commands (wr_en/wr_addr/wr_id/wr_len) with linear addresses inside a frame buffer.
- Supplies beat data combinationally on the controller's wr_ready, and pulses wr_done at end of frame so the controller toggles its port flag.

Parameters:
CTRL_ADDR_WIDTH, 28, controller address width.
MEM_DQ_WIDTH, 16, DDR DQ width; beat width = MEM_DQ_WIDTH*8.
PIX_WIDTH, 16, input pixel width; PIX_PER_BEAT = MEM_DQ_WIDTH*8/PIX_WIDTH (8 by default).
BURST_LEN, 16, beats per command, 1..16; wr_len = BURST_LEN-1.
FRAME_BEATS, 115200, beats per frame; must be a multiple of BURST_LEN.
FIFO_DEPTH, 64, beat FIFO depth, power of 2, >= 2*BURST_LEN.
FRAME_BASE0, 28'h0000000, frame buffer 0 base address.
FRAME_BASE1, 28'h0200000, frame buffer 1 base address.
WR_ID, 4'd0, constant AXI ID driven on wr_id.

Ports:
clk  in  1  clock
rst_n  in  1  reset
pix_vsync  in  1  frame sync; rising edge = new frame
pix_de  in  1  pixel valid
pix_data  in  PIX_WIDTH  pixel value
wr_en  out  1  one-cycle command strobe
wr_addr  out  CTRL_ADDR_WIDTH  burst start address
wr_id  out  4  burst ID
wr_len  out  4  burst length minus one
wr_ready  in  1  beat accepted this cycle
wr_data  out  MEM_DQ_WIDTH*8  FIFO head beat
wr_cmd_done  in  1  last beat of burst (informational)
wr_done  out  1  one-cycle end-of-frame pulse
frame_sel  out  1  buffer currently being written
fifo_ovf  out  1  sticky overflow flag

Behaviour:
- Reset: rst_n synchronous, active-low; clock clk. On reset: wr_en=0, wr_addr=FRAME_BASE0, wr_id=WR_ID, wr_len=BURST_LEN-1, wr_done=0, frame_sel=0, fifo_ovf=0; FIFO empty, pack counter 0, state IDLE, frame not armed. Reset mid-burst abandons the burst immediately.
- Packing: each pix_de cycle writes pix_data into the slot indexed by the pack counter; pixel 0 goes to bits [PIX_WIDTH-1:0]. When the counter wraps from PIX_PER_BEAT-1, the completed beat is pushed to the FIFO on the next cycle.
- Pixel acceptance: pixels are accepted only while the frame is armed.
- Overflow: a push while the FIFO is full drops the beat and sets fifo_ovf. fifo_ovf clears only on a vsync rising edge.
- FIFO: show-ahead. wr_data = head entry whenever non-empty, else 0. A pop occurs when wr_ready=1 in DATA. Simultaneous push and pop leave the count unchanged.
- Frame start: a pix_vsync rising edge sets start_pend. It is consumed only in IDLE, which:
  - clears FIFO and pack counter;
  - resets the beat counter to 0;
  - sets wr_addr to the selected base;
  - arms the frame.
- Vsync during REQ/DATA: the current burst completes first.
- FSM states:
  - IDLE: if start_pend, consume it as above. Else if armed and fifo_count >= BURST_LEN, go to REQ.
  - REQ: wr_en=1 for exactly one cycle, then DATA.
  - DATA: count wr_ready beats. On the BURST_LEN-th beat:
    - add BURST_LEN to the frame beat counter;
    - advance wr_addr by BURST_LEN*8 (address units are DQ words);
    - if beat counter = FRAME_BEATS, go to DONE; else go to IDLE.
  - DONE: wr_done=1 for one cycle; disarm; toggle frame_sel (see option); go to IDLE.
- Underflow: wr_ready while the FIFO is empty in DATA cannot occur, because REQ is gated on fifo_count >= BURST_LEN. If it does occur, the beat is counted and wr_data=0.
- wr_ready outside DATA is ignored; no pop.
- Address arithmetic: wraps modulo 2^CTRL_ADDR_WIDTH.

Optional Feature:
- Macro WR_FEEDER_PINGPONG_EN.
- Defined: frame_sel toggles on each DONE; the next frame starts at FRAME_BASE1 when frame_sel=1, else FRAME_BASE0.
- Undefined: frame_sel stays 0 and every frame starts at FRAME_BASE0. wr_done still pulses.

Test Plan:
- Reset, then vsync, then 128 consecutive pix_de pixels 0..127, with wr_ready high 2 cycles after wr_en -> exactly one wr_en with wr_addr=0x0000000 and wr_len=15; beat 0 = pixels 7..0 packed pixel 0 in the LSBs; 16 pops.
- Full frame with FRAME_BEATS=32 -> two bursts at 0x0 and 0x80, then a single wr_done pulse one cycle after the last beat. With PINGPONG: next frame's first wr_addr=0x0200000 and frame_sel=1. Without: first wr_addr=0x0.
- wr_ready held low, pixel stream continuing for 65 beats into a 64-deep FIFO -> fifo_ovf=1, fifo_count stays 64, no corruption of head data; next vsync clears fifo_ovf.
- Vsync mid-burst (after beat 5 of 16) -> remaining 11 beats delivered, then FIFO flushed and next wr_addr=base.
- Only 15 beats buffered -> wr_en never asserts; the 16th beat -> wr_en asserts within 2 cycles.
- rst_n low for 1 cycle during DATA -> all outputs at reset values next cycle; no wr_en until a new vsync.
